ram_load_sequencer: RTL and testbench

RAM_LOAD_SEQUENCER -- requirements
Module: ram_load_sequencer

---
 rtl/ram_load_sequencer_if.sv | 44 ++++
 rtl/ram_load_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ram_load_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_load_sequencer_if.sv
// ram_load_sequencer_if: loader stream, CPU strobe, RAM strobe and bus signals.
// The slave modport is the sequencer; the master modport is the environment
// (program source, CPU control block, RAM/bus).
interface ram_load_sequencer_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              load_mode;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              cpu_nLma;
    logic              cpu_nLmd;
    logic              cpu_nCE;
    logic              cpu_nLr;
    logic              ram_nLma;
    logic              ram_nLmd;
    logic              ram_nCE;
    logic              ram_nLr;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic [7:0]        bus_in;
    logic              cpu_hold;
    logic [ADDR_W-1:0] load_addr;
    logic              done;
    logic              err;

    modport slave (
        input  load_mode, in_valid, in_data,
        input  cpu_nLma, cpu_nLmd, cpu_nCE, cpu_nLr,
        input  bus_in,
        output in_ready,
        output ram_nLma, ram_nLmd, ram_nCE, ram_nLr,
        output bus_out, bus_oe, cpu_hold, load_addr, done, err
    );

    modport master (
        output load_mode, in_valid, in_data,
        output cpu_nLma, cpu_nLmd, cpu_nCE, cpu_nLr,
        output bus_in,
        input  in_ready,
        input  ram_nLma, ram_nLmd, ram_nCE, ram_nLr,
        input  bus_out, bus_oe, cpu_hold, load_addr, done, err
    );
endinterface

// File: rtl/ram_load_sequencer.sv
// ram_load_sequencer: streams program bytes into a MAR/RAM pair by taking over
// the RAM strobes and the bus, one ADDR/DATA/WRITE sequence per byte.
// Optional feature macro: LOADER_READBACK_EN adds a VERIFY cycle that reads the
// byte back and raises a sticky err on mismatch.
module ram_load_sequencer #(
    parameter int unsigned RAM_DEPTH = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_load_sequencer_if.slave  lif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE, S_VERIFY
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic              done_q, done_d;
    logic [7:0]        hold_q, hold_d;

    logic              in_ready;
    logic              seq_end;
    logic              own;
    logic              seq_nLma, seq_nLmd, seq_nCE, seq_nLr;
    logic [7:0]        bus_out;
    logic              bus_oe;

    // State, address counter, done flag and held byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_addr_q <= '0;
            done_q      <= 1'b0;
            hold_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state: accept a byte in IDLE, walk ADDR->DATA->WRITE(->VERIFY), then bump the address
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        done_d      = done_q;
        hold_d      = hold_q;
        seq_end     = 1'b0;
        in_ready    = (state_q == S_IDLE) && lif.load_mode && !done_q;

        case (state_q)
            S_IDLE: begin
                if (done_q && !lif.load_mode) begin
                    done_d      = 1'b0;
                    load_addr_d = '0;
                end else if (in_ready && lif.in_valid) begin
                    hold_d  = lif.in_data;
                    state_d = S_ADDR;
                end
            end
            S_ADDR:  state_d = S_DATA;
            S_DATA:  state_d = S_WRITE;
`ifdef LOADER_READBACK_EN
            S_WRITE:  state_d = S_VERIFY;
            S_VERIFY: seq_end = 1'b1;
`else
            S_WRITE:  seq_end = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase

        // Last cycle of a byte sequence: return to IDLE and advance (wrapping) address
        if (seq_end) begin
            state_d     = S_IDLE;
            load_addr_d = load_addr_q + ADDR_W'(1);
            if (load_addr_q == LAST_ADDR) begin
                done_d = 1'b1;
            end
        end
    end

    // Strobe and bus decode for the current sequence step
    always_comb begin
        seq_nLma = 1'b1;
        seq_nLmd = 1'b1;
        seq_nCE  = 1'b1;
        seq_nLr  = 1'b1;
        bus_out  = 8'h00;
        bus_oe   = 1'b0;
        case (state_q)
            S_ADDR: begin
                bus_out  = 8'(load_addr_q);
                bus_oe   = 1'b1;
                seq_nLma = 1'b0;
            end
            S_DATA: begin
                bus_out  = hold_q;
                bus_oe   = 1'b1;
                seq_nLmd = 1'b0;
            end
            S_WRITE: begin
                seq_nLr = 1'b0;
            end
`ifdef LOADER_READBACK_EN
            S_VERIFY: begin
                seq_nCE = 1'b0;
            end
`endif
            default: begin
                bus_oe = 1'b0;
            end
        endcase
    end

    // Loader owns the RAM strobes whenever it is requested or mid-sequence
    assign own = lif.load_mode || (state_q != S_IDLE);

    assign lif.ram_nLma  = own ? seq_nLma : lif.cpu_nLma;
    assign lif.ram_nLmd  = own ? seq_nLmd : lif.cpu_nLmd;
    assign lif.ram_nCE   = own ? seq_nCE  : lif.cpu_nCE;
    assign lif.ram_nLr   = own ? seq_nLr  : lif.cpu_nLr;
    assign lif.cpu_hold  = own;
    assign lif.in_ready  = in_ready;
    assign lif.bus_out   = bus_out;
    assign lif.bus_oe    = bus_oe;
    assign lif.load_addr = load_addr_q;
    assign lif.done      = done_q;

`ifdef LOADER_READBACK_EN
    logic err_q, err_d;

    // Sticky readback mismatch detection during VERIFY
    always_comb begin
        err_d = err_q;
        if ((state_q == S_VERIFY) && (lif.bus_in != hold_q)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign lif.err = err_q;
`else
    logic unused_bus_in;

    assign unused_bus_in = ^lif.bus_in;
    assign lif.err       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_load_sequencer.sv
// tb_ram_load_sequencer: directed stimulus for the RAM load sequencer, with a
// transaction-level model checked every cycle plus hand-computed expectations.
module tb_ram_load_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
`ifdef LOADER_READBACK_EN
    localparam int SEQ_LEN = 4;
    localparam bit RB      = 1'b1;
`else
    localparam int SEQ_LEN = 3;
    localparam bit RB      = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;
    bit   corrupt;

    ram_load_sequencer_if #(.ADDR_W(AW)) lif ();

    ram_load_sequencer #(.RAM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .lif (lif)
    );

    always #5 clk = ~clk;

    // Simple MAR/MDR/RAM that reacts to the driven strobes
    logic [7:0]    ram [DEPTH];
    logic [AW-1:0] mar;
    logic [7:0]    mdr;

    always @(posedge clk) begin
        if (!lif.ram_nLma) mar <= lif.bus_out[AW-1:0];
        if (!lif.ram_nLmd) mdr <= lif.bus_out;
        if (!lif.ram_nLr)  ram[mar] <= mdr;
    end

    assign lif.bus_in = (!lif.ram_nCE) ? (corrupt ? 8'hFF : ram[mar]) : 8'h00;

    // Transaction model: m_step counts cycles into the current byte (0 = idle)
    int         m_step;
    int         m_addr;
    bit         m_done;
    bit         m_err;
    logic [7:0] m_byte;
    bit         m_rdy;

    always @(posedge clk) begin
        m_rdy = (m_step == 0) && lif.load_mode && !m_done;
        if (rst) begin
            m_step = 0;
            m_addr = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_byte = 8'h00;
        end else if (m_step == 0) begin
            if (m_done && !lif.load_mode) begin
                m_done = 1'b0;
                m_addr = 0;
            end else if (m_rdy && lif.in_valid) begin
                m_byte = lif.in_data;
                m_step = 1;
            end
        end else if (m_step < SEQ_LEN) begin
            m_step = m_step + 1;
        end else begin
            if (RB && corrupt && (m_byte != 8'hFF)) m_err = 1'b1;
            if (m_addr == int'(DEPTH) - 1) m_done = 1'b1;
            m_addr = (m_addr + 1) % int'(DEPTH);
            m_step = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    bit own_m;
    always @(negedge clk) begin
        if (chk_en) begin
            own_m = lif.load_mode || (m_step != 0);
            chk("m_in_ready", 32'(lif.in_ready), 32'((m_step == 0) && lif.load_mode && !m_done));
            chk("m_bus_oe",   32'(lif.bus_oe),   32'((m_step == 1) || (m_step == 2)));
            if (m_step == 1) chk("m_bus_out_addr", 32'(lif.bus_out), 32'(m_addr));
            if (m_step == 2) chk("m_bus_out_data", 32'(lif.bus_out), 32'(m_byte));
            chk("m_nLma", 32'(lif.ram_nLma), 32'(own_m ? (m_step != 1) : lif.cpu_nLma));
            chk("m_nLmd", 32'(lif.ram_nLmd), 32'(own_m ? (m_step != 2) : lif.cpu_nLmd));
            chk("m_nLr",  32'(lif.ram_nLr),  32'(own_m ? (m_step != 3) : lif.cpu_nLr));
            chk("m_nCE",  32'(lif.ram_nCE),  32'(own_m ? (m_step != 4) : lif.cpu_nCE));
            chk("m_cpu_hold",  32'(lif.cpu_hold),  32'(own_m));
            chk("m_load_addr", 32'(lif.load_addr), 32'(m_addr));
            chk("m_done", 32'(lif.done), 32'(m_done));
            chk("m_err",  32'(lif.err),  32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic v);
        lif.cpu_nLma = v;
        lif.cpu_nLmd = v;
        lif.cpu_nCE  = v;
        lif.cpu_nLr  = v;
    endtask

    // Offer a byte, wait (bounded) for acceptance; returns in the ADDR cycle
    task automatic send_byte(input logic [7:0] d, input bit keep_valid);
        int n;
        n = 0;
        lif.in_data  = d;
        lif.in_valid = 1'b1;
        #1;
        while (!lif.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(lif.in_ready), 32'd1);
        tick();
        if (!keep_valid) lif.in_valid = 1'b0;
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        checks       = 0;
        failures     = 0;
        chk_en       = 1'b0;
        corrupt      = 1'b0;
        lif.load_mode = 1'b0;
        lif.in_valid  = 1'b0;
        lif.in_data   = 8'h00;
        set_cpu(1'b1);
        mar = '0;
        mdr = 8'h00;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = 8'h00;

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_bus_oe",   32'(lif.bus_oe),    32'd0);
        chk("rst_done",     32'(lif.done),      32'd0);
        chk("rst_load_addr",32'(lif.load_addr), 32'd0);
        chk("rst_err",      32'(lif.err),       32'd0);
        chk("rst_cpu_hold", 32'(lif.cpu_hold),  32'd0);
        chk("rst_in_ready", 32'(lif.in_ready),  32'd0);
        chk("rst_nCE",      32'(lif.ram_nCE),   32'd1);

        // Single byte 0xA5, load_mode and in_valid rising together
        lif.load_mode = 1'b1;
        send_byte(8'hA5, 1'b0);
        chk("a5_addr_bus",  32'(lif.bus_out),  32'h00);
        chk("a5_addr_oe",   32'(lif.bus_oe),   32'd1);
        chk("a5_addr_nLma", 32'(lif.ram_nLma), 32'd0);
        tick();
        chk("a5_data_bus",  32'(lif.bus_out),  32'hA5);
        chk("a5_data_nLmd", 32'(lif.ram_nLmd), 32'd0);
        tick();
        chk("a5_write_nLr", 32'(lif.ram_nLr),  32'd0);
        chk("a5_write_oe",  32'(lif.bus_oe),   32'd0);
        if (RB) tick();
        tick();
        chk("a5_load_addr", 32'(lif.load_addr), 32'd1);
        chk("a5_ram0",      32'(ram[0]),        32'hA5);

        // Stream 16 bytes with in_valid held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) send_byte(8'(i), 1'b1);
        lif.in_valid = 1'b0;
        repeat (SEQ_LEN) tick();
        chk("stream_done",      32'(lif.done),      32'd1);
        chk("stream_load_addr", 32'(lif.load_addr), 32'd0);
        chk("stream_in_ready",  32'(lif.in_ready),  32'd0);
        for (int i = 0; i < int'(DEPTH); i++) chk("stream_ram", 32'(ram[i]), 32'(i));

        // Release: done clears, CPU strobes pass straight through
        lif.load_mode = 1'b0;
        tick();
        chk("rel_done",      32'(lif.done),      32'd0);
        chk("rel_load_addr", 32'(lif.load_addr), 32'd0);
        lif.cpu_nCE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lif.cpu_nLr = i[0];
            #1;
            chk("pass_nLr",  32'(lif.ram_nLr),  32'(i[0]));
            chk("pass_nCE",  32'(lif.ram_nCE),  32'd0);
            chk("pass_hold", 32'(lif.cpu_hold), 32'd0);
            tick();
        end

        // load_mode drops during DATA; CPU strobes all low are ignored while owned
        lif.load_mode = 1'b1;
        set_cpu(1'b0);
        send_byte(8'h5A, 1'b0);
        chk("drop_addr_nCE", 32'(lif.ram_nCE), 32'd1);
        chk("drop_addr_nLr", 32'(lif.ram_nLr), 32'd1);
        tick();
        lif.load_mode = 1'b0;
        #1;
        chk("drop_data_hold", 32'(lif.cpu_hold), 32'd1);
        chk("drop_data_nLma", 32'(lif.ram_nLma), 32'd1);
        tick();
        chk("drop_write_nLr",  32'(lif.ram_nLr),  32'd0);
        chk("drop_write_nLma", 32'(lif.ram_nLma), 32'd1);
        if (RB) tick();
        tick();
        chk("drop_idle_nLma", 32'(lif.ram_nLma),  32'd0);
        chk("drop_idle_hold", 32'(lif.cpu_hold),  32'd0);
        chk("drop_load_addr", 32'(lif.load_addr), 32'd1);

        // Reset during ADDR aborts the write
        set_cpu(1'b1);
        lif.load_mode = 1'b1;
        send_byte(8'h77, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_oe",       32'(lif.bus_oe),    32'd0);
        chk("abort_addr",     32'(lif.load_addr), 32'd0);
        chk("abort_nLr",      32'(lif.ram_nLr),   32'd1);
        chk("abort_in_ready", 32'(lif.in_ready),  32'd1);
        repeat (4) tick();

        // Corrupted readback of 0x3C (err only exists with readback enabled)
        corrupt = 1'b1;
        send_byte(8'h3C, 1'b0);
        repeat (SEQ_LEN) tick();
        corrupt = 1'b0;
        chk("rb_err_set", 32'(lif.err), 32'(RB));
        send_byte(8'h11, 1'b0);
        repeat (SEQ_LEN) tick();
        chk("rb_err_sticky", 32'(lif.err), 32'(RB));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_err_clear", 32'(lif.err), 32'd0);
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
